// File: rtl/pe_array_pkg.sv
// Shared constants and state type for the PE array operand feeder.
package pe_array_pkg;

  localparam int unsigned NUM_ROW    = 128;
  localparam int unsigned NUM_COL    = 64;
  localparam int unsigned WIDTH_DATA = 8;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned CNT_W      = 16;

  localparam int unsigned ROW_W   = NUM_ROW * WIDTH_DATA;
  localparam int unsigned COL_W   = NUM_COL * WIDTH_DATA;
  localparam int unsigned VEC_W   = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int unsigned BPV_ROW = ROW_W / BEAT_W;
  localparam int unsigned BPV_COL = COL_W / BEAT_W;
  localparam int unsigned BPV_MAX = VEC_W / BEAT_W;
  localparam int unsigned BCNT_W  = $clog2(BPV_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_e;

endpackage

// File: rtl/pe_vec_assembler.sv
// Gathers input beats into one vector; holds a completed vector while the
// output register is still occupied.
module pe_vec_assembler
  import pe_array_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              mode_col_i,
  input  logic              beat_fire_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              take_i,
  input  logic              release_i,
  output logic [VEC_W-1:0]  vec_o,
  output logic              last_o,
  output logic              asm_full_o
);

  logic [BCNT_W-1:0] cnt_q, cnt_d, bpv_m1;
  logic [VEC_W-1:0]  buf_q, merged;
  logic              full_q;

  assign bpv_m1     = mode_col_i ? BCNT_W'(BPV_COL - 1) : BCNT_W'(BPV_ROW - 1);
  assign last_o     = beat_fire_i && (cnt_q == bpv_m1);
  assign cnt_d      = last_o ? '0 : cnt_q + BCNT_W'(1);
  assign asm_full_o = full_q;
  assign vec_o      = merged;

  // Stored beats with the current beat overlaid, so the final beat can reach
  // the output register in the same cycle it arrives.
  always_comb begin
    merged = buf_q;
    if (beat_fire_i) begin
      for (int unsigned k = 0; k < BPV_MAX; k++) begin
        if (cnt_q == BCNT_W'(k)) merged[k*BEAT_W +: BEAT_W] = beat_i;
      end
    end
  end

  // Beat counter, assembly buffer and full flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (beat_fire_i) begin
        buf_q <= merged;
        cnt_q <= cnt_d;
      end
      if (last_o && !take_i) full_q <= 1'b1;
      else if (release_i)    full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_array_feeder.sv
// Assembles row/column operand vectors from a beat stream and presents them
// to the PE array over a valid/ready handshake.
module pe_array_feeder
  import pe_array_pkg::*;
(
  input  logic             clk_p,
  input  logic             rst_p,
  input  logic             start,
  input  logic             mode_col,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [BEAT_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ROW_W-1:0] data_row,
  output logic [COL_W-1:0] data_col,
  output logic             r_c_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_idx
);

  state_e           state_q;
  logic             mode_q, sel_q, busy_q, done_q, out_valid_q;
  logic [CNT_W-1:0] num_q, asm_cnt_q, asm_cnt_d, idx_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  logic [VEC_W-1:0] asm_vec;
  logic             last_beat, asm_full, beat_fire, out_hs, out_free;
  logic             take, release_v, load, clear;

  assign in_ready  = (state_q == FILL) && !asm_full && (asm_cnt_q != num_q);
  assign beat_fire = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign take      = last_beat && out_free;
  assign release_v = asm_full && out_hs;
  assign load      = take || release_v;
  assign clear     = (state_q == IDLE) && start && (num_vec != '0);
  assign asm_cnt_d = asm_cnt_q + CNT_W'(1);

  assign data_row  = row_q;
  assign data_col  = col_q;
  assign r_c_sel   = sel_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_idx   = idx_q;

  pe_vec_assembler u_asm (
    .clk_i       (clk_p),
    .rst_i       (rst_p),
    .clear_i     (clear),
    .mode_col_i  (mode_q),
    .beat_fire_i (beat_fire),
    .beat_i      (in_data),
    .take_i      (take),
    .release_i   (release_v),
    .vec_o       (asm_vec),
    .last_o      (last_beat),
    .asm_full_o  (asm_full)
  );

  // Job FSM, output register and job counters.
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      num_q       <= '0;
      asm_cnt_q   <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      done_q <= 1'b0;
      // A direct load and a buffer release never coincide: in_ready is low
      // while the assembler holds a vector.
      if (load) begin
        out_valid_q <= 1'b1;
        if (mode_q) begin
          col_q <= asm_vec[COL_W-1:0];
          row_q <= '0;
        end else begin
          row_q <= asm_vec[ROW_W-1:0];
          col_q <= '0;
        end
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
      if (out_hs) idx_q <= idx_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_vec != '0) begin
              mode_q    <= mode_col;
              sel_q     <= mode_col;
              num_q     <= num_vec;
              asm_cnt_q <= '0;
              idx_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= FILL;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (last_beat) begin
            asm_cnt_q <= asm_cnt_d;
            if (asm_cnt_d == num_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs && !asm_full) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Self-checking bench for pe_array_feeder: expected vectors come from the
// beat stream the bench sends, cut into vectors by the packing rule.
module tb_pe_array_feeder;
  import pe_array_pkg::*;

  logic              clk_p = 1'b0;
  logic              rst_p, start, mode_col, in_valid, in_ready;
  logic [CNT_W-1:0]  num_vec, vec_idx;
  logic [BEAT_W-1:0] in_data;
  logic [ROW_W-1:0]  data_row;
  logic [COL_W-1:0]  data_col;
  logic              r_c_sel, out_valid, out_ready, busy, done;

  pe_array_feeder dut (
    .clk_p     (clk_p),
    .rst_p     (rst_p),
    .start     (start),
    .mode_col  (mode_col),
    .num_vec   (num_vec),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_row  (data_row),
    .data_col  (data_col),
    .r_c_sel   (r_c_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .vec_idx   (vec_idx)
  );

  always #5 clk_p = ~clk_p;

  int passed = 0;
  int total  = 0;

  logic [BEAT_W-1:0] beats[$];
  logic [ROW_W-1:0]  exp_q[$];
  bit                exp_mode;
  int                beat_ptr, exp_idx, done_cnt, cyc, hs_cyc, done_cyc;
  int                beat_cyc[$];
  int                rise_cyc[$];
  bit                busy_at_done;
  bit                prev_hold, prev_valid, prev_sel;
  logic [ROW_W-1:0]  prev_row;
  logic [COL_W-1:0]  prev_col;
  bit                st_pend, st_mode;
  logic [CNT_W-1:0]  st_num;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    int unsigned first;
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      first = 0;
      for (int unsigned i = ROW_W/8; i > 0; i--)
        if (obs[(i-1)*8 +: 8] !== exp[(i-1)*8 +: 8]) first = i - 1;
      $error("FAIL %s: byte %0d observed %h expected %h", tag, first,
             obs[first*8 +: 8], exp[first*8 +: 8]);
    end
  endtask

  // Build the beat stream and the vectors it must produce, and arm a start.
  task automatic prep_job(input bit mode, input int n, input bit seq);
    int bpv;
    logic [BEAT_W-1:0] b;
    logic [ROW_W-1:0]  v;
    bpv = mode ? int'(BPV_COL) : int'(BPV_ROW);
    beats.delete(); exp_q.delete(); beat_cyc.delete(); rise_cyc.delete();
    for (int k = 0; k < n*bpv; k++) begin
      if (seq) for (int j = 0; j < int'(BEAT_W/8); j++) b[j*8 +: 8] = 8'((k*8 + j) % 256);
      else     b = BEAT_W'({$urandom, $urandom});
      beats.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      v = '0;
      for (int k = 0; k < bpv; k++) v[k*BEAT_W +: BEAT_W] = beats[i*bpv + k];
      exp_q.push_back(v);
    end
    beat_ptr = 0; exp_idx = 0; done_cnt = 0; exp_mode = mode;
    st_pend = 1'b1; st_mode = mode; st_num = CNT_W'(n);
  endtask

  // One clock: drive at the falling edge, observe, then let the rising edge act.
  task automatic tick(input int pv, input int pr);
    @(negedge clk_p);
    start    = st_pend;
    mode_col = st_mode;
    num_vec  = st_num;
    st_pend  = 1'b0;
    in_valid = ($urandom_range(99) < pv);
    in_data  = (beat_ptr < beats.size()) ? beats[beat_ptr] : BEAT_W'({$urandom, $urandom});
    out_ready = ($urandom_range(99) < pr);
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk_vec("hold_row", data_row, prev_row);
      chk_vec("hold_col", ROW_W'(data_col), ROW_W'(prev_col));
      chk("hold_sel", r_c_sel, prev_sel);
    end
    if (out_valid && !prev_valid) rise_cyc.push_back(cyc);
    if (done) begin
      done_cnt++; done_cyc = cyc; busy_at_done = busy;
    end
    if (in_valid && in_ready) begin
      if (beat_ptr >= beats.size()) chk("beat_overrun", beat_ptr, beats.size());
      beat_cyc.push_back(cyc);
      beat_ptr++;
    end
    if (out_valid && out_ready) begin
      chk("vec_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("r_c_sel", r_c_sel, exp_mode);
        chk("vec_idx", vec_idx, CNT_W'(exp_idx));
        if (exp_mode) begin
          chk_vec("data_col", ROW_W'(data_col), exp_q[0]);
          chk_vec("data_row_zero", data_row, '0);
        end else begin
          chk_vec("data_row", data_row, exp_q[0]);
          chk_vec("data_col_zero", ROW_W'(data_col), '0);
        end
        void'(exp_q.pop_front());
      end
      exp_idx++;
      hs_cyc = cyc;
    end
    prev_hold  = out_valid && !out_ready;
    prev_valid = out_valid;
    prev_row   = data_row;
    prev_col   = data_col;
    prev_sel   = r_c_sel;
    cyc++;
    @(posedge clk_p);
  endtask

  task automatic run_until_done(input int pv, input int pr, input int budget, input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick(pv, pr);
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_r_c_sel"}, r_c_sel, 0);
    chk({tag, "_vec_idx"}, vec_idx, 0);
    chk_vec({tag, "_data_row"}, data_row, '0);
    chk_vec({tag, "_data_col"}, ROW_W'(data_col), '0);
  endtask

  initial begin
    rst_p = 1'b1; start = 1'b0; mode_col = 1'b0; num_vec = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    st_pend = 1'b0; st_mode = 1'b0; st_num = '0;
    prev_hold = 1'b0; prev_valid = 1'b0; cyc = 0;
    #13;
    chk_all_zero("reset");
    @(negedge clk_p);
    rst_p = 1'b0;

    // Row job, streaming at full rate, byte i of the stream = i mod 256.
    prep_job(1'b0, 2, 1'b1);
    tick(100, 100);
    run_until_done(100, 100, 200, "t1");
    chk("t1_beats", beat_ptr, 32);
    chk("t1_back_to_back", beat_cyc[31] - beat_cyc[0], 31);
    chk("t1_rise0", rise_cyc[0], beat_cyc[15] + 1);
    chk("t1_rise1", rise_cyc[1], beat_cyc[31] + 1);
    chk("t1_done_lat", done_cyc, hs_cyc + 1);
    chk("t1_busy_at_done", busy_at_done, 0);
    chk("t1_left", exp_q.size(), 0);

    // Column job with the array stalled: second vector parks in the assembler.
    prep_job(1'b1, 3, 1'b0);
    repeat (20) tick(100, 0);
    #1;
    chk("t2_beats_stalled", beat_ptr, 16);
    chk("t2_in_ready_low", in_ready, 0);
    chk("t2_out_valid", out_valid, 1);
    run_until_done(100, 100, 200, "t2");
    chk("t2_left", exp_q.size(), 0);
    chk("t2_beats", beat_ptr, 24);
    chk("t2_done_cnt", done_cnt, 1);

    // Zero-length job.
    done_cnt = 0;
    st_pend = 1'b1; st_mode = 1'b0; st_num = '0;
    tick(100, 100);
    #1;
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_in_ready", in_ready, 0);
    tick(100, 100);
    tick(100, 100);
    #1;
    chk("t3_done_clear", done, 0);
    chk("t3_done_cnt", done_cnt, 1);

    // Second start mid-job must be ignored.
    prep_job(1'b0, 2, 1'b0);
    tick(100, 100);
    repeat (5) tick(70, 60);
    st_pend = 1'b1; st_mode = 1'b1; st_num = CNT_W'(5);
    tick(70, 60);
    run_until_done(70, 60, 500, "t4");
    repeat (10) tick(100, 100);
    chk("t4_left", exp_q.size(), 0);
    chk("t4_beats", beat_ptr, 32);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy", busy, 0);

    // Asynchronous reset after five beats, then a clean job.
    prep_job(1'b0, 1, 1'b0);
    tick(100, 100);
    for (int n = 0; n < 50 && beat_ptr < 5; n++) tick(100, 100);
    chk("t5_beats_before_rst", beat_ptr, 5);
    #2 rst_p = 1'b1;
    #1;
    chk_all_zero("t5_async");
    @(negedge clk_p);
    rst_p = 1'b0;
    prev_hold = 1'b0; prev_valid = 1'b0;
    prep_job(1'b0, 1, 1'b0);
    tick(100, 100);
    run_until_done(100, 100, 200, "t5");
    repeat (5) tick(100, 100);
    chk("t5_left", exp_q.size(), 0);
    chk("t5_done_cnt", done_cnt, 1);

    // Random flow control on both sides, ten column vectors.
    prep_job(1'b1, 10, 1'b0);
    tick(50, 50);
    run_until_done(50, 50, 3000, "t6");
    repeat (10) tick(50, 50);
    chk("t6_left", exp_q.size(), 0);
    chk("t6_beats", beat_ptr, 80);
    chk("t6_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
